reorder_buffer: RTL and testbench

- In-order commit stage directly downstream of issue/register-status.
- Allocates a 4-bit ROB tag per issued instruction and captures results from the CDB.
- Retires at most one instruction per cycle from the head.
- Drives the register-status table's commit_dest/commit_ROB/RegWrite/issue_ROB and its flush reset on mispredict.
- Also provides operand-value lookup for tags returned as Q_j/Q_k.

---
 rtl/reorder_buffer.sv | 164 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Reorder buffer: tags issued instructions, captures CDB results and retires in order from head.
// Optional ROB_CDB_BYPASS_EN forwards a same-cycle CDB result to the Q_j/Q_k operand lookups.
module reorder_buffer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned IDX_W = 4,
   parameter int unsigned XLEN  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic             issue_writes,
   input  logic [4:0]       issue_dest,
   input  logic             issue_is_branch,
   input  logic             issue_is_store,
   output logic [IDX_W-1:0] issue_ROB,
   output logic             rob_full,
   input  logic             cdb_valid,
   input  logic [IDX_W-1:0] cdb_ROB,
   input  logic [XLEN-1:0]  cdb_value,
   input  logic             cdb_mispredict,
   input  logic [XLEN-1:0]  cdb_target,
   input  logic [IDX_W-1:0] Q_j,
   input  logic [IDX_W-1:0] Q_k,
   output logic             qj_ready,
   output logic             qk_ready,
   output logic [XLEN-1:0]  qj_value,
   output logic [XLEN-1:0]  qk_value,
   output logic             commit_valid,
   output logic             RegWrite,
   output logic [4:0]       commit_dest,
   output logic [IDX_W-1:0] commit_ROB,
   output logic [XLEN-1:0]  commit_value,
   output logic             commit_store,
   output logic             flush,
   output logic [XLEN-1:0]  flush_pc
);

   typedef struct packed {
      logic            busy;
      logic            ready;
      logic            writes;
      logic [4:0]      dest;
      logic            is_branch;
      logic            is_store;
      logic            mispredict;
      logic [XLEN-1:0] value;
      logic [XLEN-1:0] target;
   } entry_t;

   localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);
   localparam logic [IDX_W:0]   CntOne  = (IDX_W + 1)'(1);
   localparam logic [IDX_W:0]   CntFull = DEPTH[IDX_W:0];

   entry_t           entry_q [DEPTH];
   entry_t           entry_d [DEPTH];
   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [IDX_W:0]   count_q, count_d;

   entry_t head_e;
   entry_t cdb_e;
   logic   alloc;
   logic   complete;

   always_comb begin
      head_e       = entry_q[head_q];
      cdb_e        = entry_q[cdb_ROB];
      rob_full     = (count_q == CntFull);
      issue_ROB    = tail_q;
      commit_valid = head_e.busy & head_e.ready;
      flush        = commit_valid & head_e.mispredict;
      flush_pc     = flush ? head_e.target : '0;
      RegWrite     = commit_valid & head_e.writes;
      commit_store = commit_valid & head_e.is_store;
      commit_dest  = head_e.dest;
      commit_ROB   = head_q;
      commit_value = head_e.value;
      alloc        = issue_valid & ~rob_full & ~flush;
      // An entry retiring on this edge must not be re-marked by a late CDB hit.
      complete     = cdb_valid & cdb_e.busy & ~cdb_e.ready & ~flush
                     & ~(commit_valid & (cdb_ROB == head_q));
   end

   always_comb begin
      entry_d = entry_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            entry_d[i].busy       = 1'b0;
            entry_d[i].ready      = 1'b0;
            entry_d[i].mispredict = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (alloc) begin
            entry_d[tail_q].busy       = 1'b1;
            entry_d[tail_q].ready      = 1'b0;
            entry_d[tail_q].mispredict = 1'b0;
            entry_d[tail_q].writes     = issue_writes;
            entry_d[tail_q].dest       = issue_dest;
            entry_d[tail_q].is_branch  = issue_is_branch;
            entry_d[tail_q].is_store   = issue_is_store;
            tail_d                     = tail_q + IdxOne;
         end
         if (complete) begin
            entry_d[cdb_ROB].ready      = 1'b1;
            entry_d[cdb_ROB].value      = cdb_value;
            entry_d[cdb_ROB].mispredict = cdb_mispredict & cdb_e.is_branch;
            entry_d[cdb_ROB].target     = cdb_target;
         end
         if (commit_valid) begin
            entry_d[head_q].busy  = 1'b0;
            entry_d[head_q].ready = 1'b0;
            head_d                = head_q + IdxOne;
         end
         case ({alloc, commit_valid})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      qj_ready = entry_q[Q_j].ready;
      qj_value = entry_q[Q_j].value;
      qk_ready = entry_q[Q_k].ready;
      qk_value = entry_q[Q_k].value;
`ifdef ROB_CDB_BYPASS_EN
      if (cdb_valid && (cdb_ROB == Q_j) && entry_q[Q_j].busy) begin
         qj_ready = 1'b1;
         qj_value = cdb_value;
      end
      if (cdb_valid && (cdb_ROB == Q_k) && entry_q[Q_k].busy) begin
         qk_ready = 1'b1;
         qk_value = cdb_value;
      end
`else
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            entry_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            entry_q[i] <= entry_d[i];
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table for in-order commit and flush,
// plus hand sequences for reset, fill, wrap and operand lookup timing.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid, issue_writes, issue_is_branch, issue_is_store;
   logic [4:0]  issue_dest;
   logic [3:0]  issue_ROB;
   logic        rob_full;
   logic        cdb_valid, cdb_mispredict;
   logic [3:0]  cdb_ROB;
   logic [31:0] cdb_value, cdb_target;
   logic [3:0]  Q_j, Q_k;
   logic        qj_ready, qk_ready;
   logic [31:0] qj_value, qk_value;
   logic        commit_valid, RegWrite, commit_store, flush;
   logic [4:0]  commit_dest;
   logic [3:0]  commit_ROB;
   logic [31:0] commit_value, flush_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_dest(issue_dest),
      .issue_is_branch(issue_is_branch), .issue_is_store(issue_is_store),
      .issue_ROB(issue_ROB), .rob_full(rob_full),
      .cdb_valid(cdb_valid), .cdb_ROB(cdb_ROB), .cdb_value(cdb_value),
      .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
      .Q_j(Q_j), .Q_k(Q_k), .qj_ready(qj_ready), .qk_ready(qk_ready),
      .qj_value(qj_value), .qk_value(qk_value),
      .commit_valid(commit_valid), .RegWrite(RegWrite), .commit_dest(commit_dest),
      .commit_ROB(commit_ROB), .commit_value(commit_value), .commit_store(commit_store),
      .flush(flush), .flush_pc(flush_pc)
   );

   typedef struct {
      logic        iv, iw;
      logic [4:0]  idst;
      logic        ibr, ist;
      logic        cv;
      logic [3:0]  crob;
      logic [31:0] cval;
      logic        cmis;
      logic [31:0] ctgt;
      logic [3:0]  qj;
      logic [3:0]  e_irob;
      logic        e_full, e_cv, e_rw;
      logic [4:0]  e_dst;
      logic [3:0]  e_crob;
      logic [31:0] e_cval;
      logic        e_st, e_fl;
      logic [31:0] e_fpc;
      logic        e_qjr;
      logic [31:0] e_qjv;
   } vec_t;

   vec_t vecs [18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic idle();
      issue_valid = 0; issue_writes = 0; issue_dest = 0; issue_is_branch = 0;
      issue_is_store = 0; cdb_valid = 0; cdb_ROB = 0; cdb_value = 0;
      cdb_mispredict = 0; cdb_target = 0; Q_j = 0; Q_k = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      idle();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic issue(input logic w, input logic [4:0] d);
      idle();
      issue_valid = 1; issue_writes = w; issue_dest = d;
      tick();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      // Field order: iv iw idst ibr ist | cv crob cval cmis ctgt | qj ||
      //   e_irob e_full e_cv e_rw e_dst e_crob e_cval e_st e_fl e_fpc e_qjr e_qjv
      vecs[0]  = '{1,1,5,0,0, 0,0,0,0,0, 0,  0,0,0,0,0,0,0,0,0,0, 0,0};
      vecs[1]  = '{1,1,6,0,0, 0,0,0,0,0, 0,  1,0,0,0,0,0,0,0,0,0, 0,0};
      vecs[2]  = '{1,0,7,0,1, 0,0,0,0,0, 0,  2,0,0,0,0,0,0,0,0,0, 0,0};
      vecs[3]  = '{0,0,0,0,0, 1,2,32'h22,0,0, 0,  3,0,0,0,0,0,0,0,0,0, 0,0};
      vecs[4]  = '{0,0,0,0,0, 1,0,32'h100,0,0, 2,  3,0,0,0,0,0,0,0,0,0, 1,32'h22};
      vecs[5]  = '{0,0,0,0,0, 1,1,32'h11,0,0, 0,  3,0,1,1,5,0,32'h100,0,0,0, 1,32'h100};
      vecs[6]  = '{0,0,0,0,0, 0,0,0,0,0, 1,  3,0,1,1,6,1,32'h11,0,0,0, 1,32'h11};
      vecs[7]  = '{0,0,0,0,0, 0,0,0,0,0, 0,  3,0,1,0,7,2,32'h22,1,0,0, 0,0};
      vecs[8]  = '{0,0,0,0,0, 0,0,0,0,0, 0,  3,0,0,0,0,0,0,0,0,0, 0,0};
      vecs[9]  = '{1,0,0,1,0, 0,0,0,0,0, 0,  3,0,0,0,0,0,0,0,0,0, 0,0};
      vecs[10] = '{1,1,9,0,0, 0,0,0,0,0, 0,  4,0,0,0,0,0,0,0,0,0, 0,0};
      vecs[11] = '{1,1,10,0,0, 0,0,0,0,0, 0,  5,0,0,0,0,0,0,0,0,0, 0,0};
      vecs[12] = '{0,0,0,0,0, 1,4,32'h44,0,0, 0,  6,0,0,0,0,0,0,0,0,0, 0,0};
      vecs[13] = '{0,0,0,0,0, 1,3,0,1,32'h100, 4,  6,0,0,0,0,0,0,0,0,0, 1,32'h44};
      vecs[14] = '{1,1,11,0,0, 1,5,32'h55,0,0, 4,  6,0,1,0,0,3,0,0,1,32'h100, 1,32'h44};
      vecs[15] = '{0,0,0,0,0, 0,0,0,0,0, 4,  0,0,0,0,0,0,0,0,0,0, 0,0};
      vecs[16] = '{0,0,0,0,0, 0,0,0,0,0, 5,  0,0,0,0,0,0,0,0,0,0, 0,0};
      vecs[17] = '{0,0,0,0,0, 0,0,0,0,0, 0,  0,0,0,0,0,0,0,0,0,0, 0,0};

      // Reset state
      idle();
      reset = 1;
      tick();
      tick();
      chk("rst_commit_valid", 32'(commit_valid), 0);
      chk("rst_rob_full", 32'(rob_full), 0);
      chk("rst_issue_ROB", 32'(issue_ROB), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_regwrite", 32'(RegWrite), 0);
      chk("rst_qj_ready", 32'(qj_ready), 0);
      reset = 0;

      // Asynchronous reset with five entries in flight and the head ready to retire
      for (int i = 0; i < 5; i++) issue(1, 5'(i + 1));
      idle();
      cdb_valid = 1; cdb_ROB = 0; cdb_value = 32'hAB;
      tick();
      idle();
      #1;
      chk("midrst_pre_commit_valid", 32'(commit_valid), 1);
      chk("midrst_pre_issue_ROB", 32'(issue_ROB), 5);
      #1;
      reset = 1;
      #1;
      chk("midrst_commit_valid", 32'(commit_valid), 0);
      chk("midrst_rob_full", 32'(rob_full), 0);
      chk("midrst_issue_ROB", 32'(issue_ROB), 0);
      chk("midrst_regwrite", 32'(RegWrite), 0);
      tick();
      reset = 0;

      // Vector table: out-of-order completion, in-order commit, then mispredict flush
      for (int v = 0; v < 18; v++) begin
         issue_valid = vecs[v].iv; issue_writes = vecs[v].iw; issue_dest = vecs[v].idst;
         issue_is_branch = vecs[v].ibr; issue_is_store = vecs[v].ist;
         cdb_valid = vecs[v].cv; cdb_ROB = vecs[v].crob; cdb_value = vecs[v].cval;
         cdb_mispredict = vecs[v].cmis; cdb_target = vecs[v].ctgt;
         Q_j = vecs[v].qj; Q_k = 0;
         #1;
         chk($sformatf("v%0d_issue_ROB", v), 32'(issue_ROB), 32'(vecs[v].e_irob));
         chk($sformatf("v%0d_rob_full", v), 32'(rob_full), 32'(vecs[v].e_full));
         chk($sformatf("v%0d_commit_valid", v), 32'(commit_valid), 32'(vecs[v].e_cv));
         chk($sformatf("v%0d_flush", v), 32'(flush), 32'(vecs[v].e_fl));
         chk($sformatf("v%0d_qj_ready", v), 32'(qj_ready), 32'(vecs[v].e_qjr));
         if (vecs[v].e_qjr) chk($sformatf("v%0d_qj_value", v), qj_value, vecs[v].e_qjv);
         if (vecs[v].e_cv) begin
            chk($sformatf("v%0d_regwrite", v), 32'(RegWrite), 32'(vecs[v].e_rw));
            chk($sformatf("v%0d_commit_dest", v), 32'(commit_dest), 32'(vecs[v].e_dst));
            chk($sformatf("v%0d_commit_ROB", v), 32'(commit_ROB), 32'(vecs[v].e_crob));
            chk($sformatf("v%0d_commit_value", v), commit_value, vecs[v].e_cval);
            chk($sformatf("v%0d_commit_store", v), 32'(commit_store), 32'(vecs[v].e_st));
         end
         if (vecs[v].e_fl) chk($sformatf("v%0d_flush_pc", v), flush_pc, vecs[v].e_fpc);
         tick();
      end
      idle();

      // Fill all sixteen entries, then confirm extra issues are dropped
      reset_pulse();
      for (int i = 0; i < 16; i++) begin
         idle();
         issue_valid = 1; issue_writes = 1; issue_dest = 5'(i);
         #1;
         chk($sformatf("fill%0d_issue_ROB", i), 32'(issue_ROB), 32'(i));
         chk($sformatf("fill%0d_rob_full", i), 32'(rob_full), 0);
         tick();
      end
      idle();
      #1;
      chk("full_rob_full", 32'(rob_full), 1);
      chk("full_issue_ROB", 32'(issue_ROB), 0);
      issue_valid = 1;
      tick();
      chk("full17_rob_full", 32'(rob_full), 1);
      chk("full17_issue_ROB", 32'(issue_ROB), 0);
      cdb_valid = 1; cdb_ROB = 0; cdb_value = 32'h5A;
      tick();
      cdb_valid = 0;
      #1;
      chk("full_commit_valid", 32'(commit_valid), 1);
      chk("full_commit_ROB", 32'(commit_ROB), 0);
      chk("full_commit_no_unblock", 32'(rob_full), 1);
      tick();
      idle();
      #1;
      chk("after_commit_rob_full", 32'(rob_full), 0);
      chk("after_commit_issue_ROB", 32'(issue_ROB), 0);
      chk("after_commit_valid", 32'(commit_valid), 0);

      // Continuous stream of 20 ops: tags and commits wrap 15 -> 0
      reset_pulse();
      for (int c = 0; c < 23; c++) begin
         idle();
         issue_valid = (c < 20); issue_writes = 1; issue_dest = 5'(c);
         cdb_valid = (c >= 1 && c <= 20); cdb_ROB = 4'(c + 15); cdb_value = 32'(c + 999);
         #1;
         chk($sformatf("wrap%0d_rob_full", c), 32'(rob_full), 0);
         if (c < 20) chk($sformatf("wrap%0d_issue_ROB", c), 32'(issue_ROB), 32'(c % 16));
         if (c >= 2 && c <= 21) begin
            chk($sformatf("wrap%0d_commit_valid", c), 32'(commit_valid), 1);
            chk($sformatf("wrap%0d_commit_ROB", c), 32'(commit_ROB), 32'((c - 2) % 16));
            chk($sformatf("wrap%0d_commit_value", c), commit_value, 32'(c + 998));
         end else begin
            chk($sformatf("wrap%0d_commit_valid", c), 32'(commit_valid), 0);
         end
         tick();
      end
      idle();

      // Operand lookup timing relative to the CDB edge
      reset_pulse();
      for (int i = 0; i < 3; i++) issue(1, 5'(i + 20));
      idle();
      Q_j = 2; Q_k = 2;
      cdb_valid = 1; cdb_ROB = 2; cdb_value = 32'hDEAD;
      #1;
`ifdef ROB_CDB_BYPASS_EN
      chk("byp_qj_ready", 32'(qj_ready), 1);
      chk("byp_qj_value", qj_value, 32'hDEAD);
      chk("byp_qk_ready", 32'(qk_ready), 1);
`else
      chk("byp_qj_ready", 32'(qj_ready), 0);
      chk("byp_qk_ready", 32'(qk_ready), 0);
`endif
      tick();
      cdb_valid = 0; cdb_value = 0;
      #1;
      chk("lookup_qj_ready", 32'(qj_ready), 1);
      chk("lookup_qj_value", qj_value, 32'hDEAD);
      chk("lookup_qk_ready", 32'(qk_ready), 1);
      chk("lookup_qk_value", qk_value, 32'hDEAD);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
